// File: rtl/nonce_tx_framer.sv
// Frames golden-nonce results onto the MIPI TX pixel interface: each buffered
// result becomes one short frame (VSYNC, HSYNC, then two 64-bit data words).
module nonce_tx_framer #(
    parameter int          FIFO_DEPTH_LOG2 = 2,
    parameter int          SYNC_CYCLES     = 4,
    parameter int          GAP_CYCLES      = 8,
    parameter logic [5:0]  DATA_TYPE       = 6'h24,
    parameter logic [15:0] MAGIC           = 16'hA55A
) (
    input  logic        tx_pixel_clk,
    input  logic        reset,
    input  logic        nonce_valid,
    input  logic [31:0] golden_nonce,
    input  logic [31:0] job_id,
    output logic        tx_valid,
    output logic        tx_hsync,
    output logic        tx_vsync,
    output logic [63:0] tx_data,
    output logic [5:0]  tx_type,
    output logic        busy,
    output logic        fifo_full,
    output logic [7:0]  drop_count
);

    localparam int DEPTH   = 1 << FIFO_DEPTH_LOG2;
    localparam int MAX_CYC = (SYNC_CYCLES > GAP_CYCLES) ? SYNC_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC) + 1;

    localparam logic [FIFO_DEPTH_LOG2:0] DEPTH_CNT = (FIFO_DEPTH_LOG2+1)'(DEPTH);
    localparam logic [CNT_W-1:0]         SYNC_LOAD = CNT_W'(SYNC_CYCLES - 1);
    localparam logic [CNT_W-1:0]         GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE, VS, VS_GAP, HS, HS_GAP, W0, W1, TAIL
    } state_t;

    state_t                     state;
    logic [CNT_W-1:0]           cnt;
    logic [7:0]                 seq;

    logic [63:0]                mem [DEPTH];
    logic [FIFO_DEPTH_LOG2-1:0] wr_ptr;
    logic [FIFO_DEPTH_LOG2-1:0] rd_ptr;
    logic [FIFO_DEPTH_LOG2:0]   count;
    logic                       push;
    logic                       pop;

    logic [31:0]                hold_job;
    logic [31:0]                hold_nonce;
    logic [31:0]                hdr;
    logic [63:0]                w0_word;
    logic [63:0]                w1_word;

    assign tx_type   = DATA_TYPE;
    assign fifo_full = (count == DEPTH_CNT);
    assign push      = nonce_valid && !fifo_full;
    assign pop       = (state == IDLE) && (count != '0);
    assign busy      = (state != IDLE) || (count != '0);

    assign hdr     = {MAGIC, 8'h01, seq};
    assign w0_word = {hdr, hold_job};
    assign w1_word = {hold_nonce, hold_job ^ hdr ^ hold_nonce};

    // A full FIFO drops the incoming result even when a pop frees a slot this cycle.
    always_ff @(posedge tx_pixel_clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            drop_count <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (nonce_valid && fifo_full && drop_count != 8'hFF)
                drop_count <= drop_count + 8'd1;
        end
    end

    always_ff @(posedge tx_pixel_clk) begin
        if (push)
            mem[wr_ptr] <= {job_id, golden_nonce};
    end

    // Frame contents are captured at pop so later pushes cannot disturb a frame in flight.
    always_ff @(posedge tx_pixel_clk) begin
        if (pop)
            {hold_job, hold_nonce} <= mem[rd_ptr];
    end

    always_ff @(posedge tx_pixel_clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            seq      <= '0;
            tx_vsync <= 1'b0;
            tx_hsync <= 1'b0;
            tx_valid <= 1'b0;
            tx_data  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        state    <= VS;
                        cnt      <= SYNC_LOAD;
                        tx_vsync <= 1'b1;
                    end
                end
                VS: begin
                    if (cnt == '0) begin
                        state    <= VS_GAP;
                        cnt      <= GAP_LOAD;
                        tx_vsync <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                VS_GAP: begin
                    if (cnt == '0) begin
                        state    <= HS;
                        cnt      <= SYNC_LOAD;
                        tx_hsync <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                HS: begin
                    if (cnt == '0) begin
                        state    <= HS_GAP;
                        cnt      <= GAP_LOAD;
                        tx_hsync <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                HS_GAP: begin
                    if (cnt == '0) begin
                        state    <= W0;
                        tx_valid <= 1'b1;
                        tx_data  <= w0_word;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                W0: begin
                    state   <= W1;
                    tx_data <= w1_word;
                end
                W1: begin
                    state    <= TAIL;
                    cnt      <= GAP_LOAD;
                    seq      <= seq + 8'd1;
                    tx_valid <= 1'b0;
                    tx_data  <= '0;
                end
                TAIL: begin
                    if (cnt == '0)
                        state <= IDLE;
                    else
                        cnt <= cnt - 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nonce_tx_framer.sv
// Randomized scoreboard bench for nonce_tx_framer: a queue-level reference model
// predicts frames and status, an independent monitor checks the TX waveform.
module tb_nonce_tx_framer;

    localparam int          L         = 2;
    localparam int          DEPTH     = 1 << L;
    localparam int          SYNC      = 4;
    localparam int          GAP       = 8;
    localparam int          FRAME_LEN = 2*SYNC + 3*GAP + 2;
    localparam logic [15:0] MAGIC     = 16'hA55A;
    localparam logic [5:0]  DT        = 6'h24;

    logic        tx_pixel_clk;
    logic        reset;
    logic        nonce_valid;
    logic [31:0] golden_nonce;
    logic [31:0] job_id;
    logic        tx_valid;
    logic        tx_hsync;
    logic        tx_vsync;
    logic [63:0] tx_data;
    logic [5:0]  tx_type;
    logic        busy;
    logic        fifo_full;
    logic [7:0]  drop_count;

    nonce_tx_framer #(
        .FIFO_DEPTH_LOG2 (L),
        .SYNC_CYCLES     (SYNC),
        .GAP_CYCLES      (GAP),
        .DATA_TYPE       (DT),
        .MAGIC           (MAGIC)
    ) dut (
        .tx_pixel_clk (tx_pixel_clk),
        .reset        (reset),
        .nonce_valid  (nonce_valid),
        .golden_nonce (golden_nonce),
        .job_id       (job_id),
        .tx_valid     (tx_valid),
        .tx_hsync     (tx_hsync),
        .tx_vsync     (tx_vsync),
        .tx_data      (tx_data),
        .tx_type      (tx_type),
        .busy         (busy),
        .fifo_full    (fifo_full),
        .drop_count   (drop_count)
    );

    initial tx_pixel_clk = 1'b0;
    always #5 tx_pixel_clk = ~tx_pixel_clk;

    typedef struct {
        logic [31:0] job;
        logic [31:0] nonce;
        logic [7:0]  seq;
        longint      start;
    } frame_t;

    frame_t      expq[$];
    logic [63:0] mq[$];
    longint      cyc     = 0;
    longint      idle_at = 0;
    logic [7:0]  mseq    = 8'd0;
    logic [7:0]  mdrop   = 8'd0;
    logic        exp_busy = 1'b0;
    logic        exp_full = 1'b0;
    int          n_checks = 0;
    int          n_fail   = 0;

    // Expected {vsync, hsync, valid, data} at a given offset into a frame.
    function automatic logic [66:0] frame_exp(input frame_t f, input int off);
        logic [31:0] hdr;
        logic        vs;
        logic        hs;
        logic        v;
        logic [63:0] d;
        int          w0off;
        hdr   = {MAGIC, 8'h01, f.seq};
        w0off = 2*SYNC + 2*GAP;
        vs    = (off < SYNC);
        hs    = (off >= SYNC + GAP) && (off < 2*SYNC + GAP);
        v     = (off == w0off) || (off == w0off + 1);
        if (off == w0off)
            d = {hdr, f.job};
        else if (off == w0off + 1)
            d = {f.nonce, f.job ^ hdr ^ f.nonce};
        else
            d = 64'd0;
        return {vs, hs, v, d};
    endfunction

    // Reference model: a result waits in a bounded queue; the framer takes the head
    // once it has been idle for a cycle and is then occupied for FRAME_LEN cycles.
    initial begin
        logic        full;
        logic [63:0] e;
        forever begin
            @(posedge tx_pixel_clk);
            cyc++;
            if (reset) begin
                mq.delete();
                expq.delete();
                idle_at = cyc;
                mseq    = 8'd0;
                mdrop   = 8'd0;
            end else begin
                full = (mq.size() == DEPTH);
                if (cyc > idle_at && mq.size() > 0) begin
                    e = mq.pop_front();
                    expq.push_back('{job: e[63:32], nonce: e[31:0], seq: mseq, start: cyc});
                    mseq    = mseq + 8'd1;
                    idle_at = cyc + FRAME_LEN;
                end
                if (nonce_valid) begin
                    if (full) begin
                        if (mdrop != 8'hFF)
                            mdrop = mdrop + 8'd1;
                    end else begin
                        mq.push_back({job_id, golden_nonce});
                    end
                end
            end
            exp_busy = (cyc < idle_at) || (mq.size() > 0);
            exp_full = (mq.size() == DEPTH);
        end
    end

    bit     mon_active = 0;
    int     mon_off    = 0;
    frame_t cur;

    task automatic check_frame_cycle();
        logic [66:0] expv;
        expv = frame_exp(cur, mon_off);
        n_checks++;
        if ({tx_vsync, tx_hsync, tx_valid, tx_data} !== expv || tx_type !== DT) begin
            n_fail++;
            $display("FAIL frame_cycle seq=%0d off=%0d got vs=%0b hs=%0b v=%0b data=%h type=%h expected vs=%0b hs=%0b v=%0b data=%h type=%h",
                     cur.seq, mon_off, tx_vsync, tx_hsync, tx_valid, tx_data, tx_type,
                     expv[66], expv[65], expv[64], expv[63:0], DT);
        end
    endtask

    task automatic check_quiet(input string name);
        n_checks++;
        if ({tx_vsync, tx_hsync, tx_valid, tx_data} !== 67'd0 || tx_type !== DT) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got vs=%0b hs=%0b v=%0b data=%h type=%h expected all zero type=%h",
                     name, cyc, tx_vsync, tx_hsync, tx_valid, tx_data, tx_type, DT);
        end
    endtask

    // Monitor: samples 1 time unit after each rising edge.
    initial begin
        forever begin
            @(posedge tx_pixel_clk);
            #1;
            n_checks++;
            if ({busy, fifo_full, drop_count} !== {exp_busy, exp_full, mdrop}) begin
                n_fail++;
                $display("FAIL status cyc=%0d got busy=%0b full=%0b drop=%0d expected busy=%0b full=%0b drop=%0d",
                         cyc, busy, fifo_full, drop_count, exp_busy, exp_full, mdrop);
            end
            if (reset) begin
                mon_active = 0;
                check_quiet("reset_outputs");
            end else begin
                if (mon_active) begin
                    mon_off++;
                    if (mon_off == FRAME_LEN)
                        mon_active = 0;
                end
                if (mon_active) begin
                    check_frame_cycle();
                end else if (tx_vsync) begin
                    n_checks++;
                    if (expq.size() == 0) begin
                        n_fail++;
                        $display("FAIL unexpected_frame cyc=%0d got vsync=1 expected no frame", cyc);
                    end else begin
                        cur        = expq.pop_front();
                        mon_active = 1;
                        mon_off    = 0;
                        if (cur.start != cyc) begin
                            n_fail++;
                            $display("FAIL frame_start seq=%0d got cyc=%0d expected cyc=%0d", cur.seq, cyc, cur.start);
                        end
                        check_frame_cycle();
                    end
                end else begin
                    check_quiet("idle_outputs");
                end
            end
        end
    end

    task automatic drive(input logic v, input logic [31:0] n, input logic [31:0] j);
        @(negedge tx_pixel_clk);
        nonce_valid  = v;
        golden_nonce = n;
        job_id       = j;
    endtask

    task automatic do_reset();
        @(negedge tx_pixel_clk);
        reset       = 1'b1;
        nonce_valid = 1'b0;
        repeat (3) @(negedge tx_pixel_clk);
        reset = 1'b0;
    endtask

    task automatic wait_idle(input int maxc);
        int k;
        k = 0;
        while (k < maxc) begin
            @(negedge tx_pixel_clk);
            if (!busy) break;
            k++;
        end
        n_checks++;
        if (k >= maxc) begin
            n_fail++;
            $display("FAIL wait_idle got busy=1 after %0d cycles expected busy=0", maxc);
        end
        repeat (3) @(negedge tx_pixel_clk);
    endtask

    task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s got %h expected %h", name, got, want);
        end
    endtask

    initial begin
        int k;
        int sent;
        reset        = 1'b1;
        nonce_valid  = 1'b0;
        golden_nonce = 32'd0;
        job_id       = 32'd0;
        repeat (3) @(negedge tx_pixel_clk);
        reset = 1'b0;
        repeat (2) @(negedge tx_pixel_clk);

        // Single result with a fixed value.
        drive(1'b1, 32'hDEADBEEF, 32'h00000007);
        drive(1'b0, 32'd0, 32'd0);
        wait_idle(200);

        // Burst of five into an idle framer.
        for (int i = 0; i < 5; i++)
            drive(1'b1, $urandom, $urandom);
        drive(1'b0, 32'd0, 32'd0);
        check_val("burst_no_drop", {24'd0, drop_count}, 32'd0);
        check_val("burst_full", {31'd0, fifo_full}, 32'd1);
        wait_idle(1000);

        // Push coinciding with the IDLE pop of a single entry.
        drive(1'b1, $urandom, $urandom);
        drive(1'b1, $urandom, $urandom);
        drive(1'b0, 32'd0, 32'd0);
        check_val("coincident_no_drop", {24'd0, drop_count}, 32'd0);
        check_val("coincident_not_full", {31'd0, fifo_full}, 32'd0);
        wait_idle(500);

        // Overflow, then saturation of the drop counter.
        for (int i = 0; i < 8; i++)
            drive(1'b1, $urandom, $urandom);
        drive(1'b0, 32'd0, 32'd0);
        check_val("overflow_drops", {24'd0, drop_count}, 32'd3);
        check_val("overflow_full", {31'd0, fifo_full}, 32'd1);
        for (int i = 0; i < 300; i++)
            drive(1'b1, $urandom, $urandom);
        drive(1'b0, 32'd0, 32'd0);
        check_val("drop_saturate", {24'd0, drop_count}, 32'h000000FF);
        wait_idle(2000);

        // Random traffic, including pushes into a full FIFO.
        for (int i = 0; i < 500; i++)
            drive(($urandom % 5) == 0, $urandom, $urandom);
        drive(1'b0, 32'd0, 32'd0);
        wait_idle(2000);

        // Reset asserted during W0 of a frame with more results queued.
        for (int i = 0; i < 3; i++)
            drive(1'b1, $urandom, $urandom);
        drive(1'b0, 32'd0, 32'd0);
        k = 0;
        while (k < 200 && !tx_valid) begin
            @(negedge tx_pixel_clk);
            k++;
        end
        check_val("reach_w0", {31'd0, tx_valid}, 32'd1);
        reset = 1'b1;
        #1;
        check_val("async_reset_valid", {31'd0, tx_valid}, 32'd0);
        check_val("async_reset_data_lo", tx_data[31:0], 32'd0);
        check_val("async_reset_data_hi", tx_data[63:32], 32'd0);
        repeat (3) @(negedge tx_pixel_clk);
        reset = 1'b0;
        repeat (60) @(negedge tx_pixel_clk);
        check_val("post_reset_busy", {31'd0, busy}, 32'd0);

        // 257 frames to exercise the sequence-number wrap.
        do_reset();
        sent = 0;
        k    = 0;
        while (sent < 257 && k < 30000) begin
            @(negedge tx_pixel_clk);
            if (!fifo_full && $urandom_range(0, 3) != 0) begin
                nonce_valid  = 1'b1;
                golden_nonce = $urandom;
                job_id       = $urandom;
                sent++;
            end else begin
                nonce_valid = 1'b0;
            end
            k++;
        end
        drive(1'b0, 32'd0, 32'd0);
        check_val("wrap_pushes", sent, 32'd257);
        wait_idle(12000);

        n_checks++;
        if (expq.size() != 0 || mon_active) begin
            n_fail++;
            $display("FAIL leftover_frames got %0d pending expected 0", expq.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
